// File: rtl/adc_pkg.sv
// Shared types and constants for the LTC2308 reader.
package adc_pkg;

  localparam int ADC_BITS = 12;
  localparam int CFG_BITS = 6;

  localparam logic CFG_SD_SINGLE = 1'b1;
  localparam logic CFG_UNIPOLAR  = 1'b1;
  localparam logic CFG_SLEEP     = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    WAIT,
    SHIFT,
    DONE
  } state_e;

  // The LTC2308 numbers its single-ended inputs as {O/S, S1, S0} = {ch[0], ch[2], ch[1]}.
  function automatic logic [CFG_BITS-1:0] build_cfg(input logic [2:0] ch);
    return {CFG_SD_SINGLE, ch[0], ch[2], ch[1], CFG_UNIPOLAR, CFG_SLEEP};
  endfunction

endpackage

// File: rtl/adc_ltc2308_reader_if.sv
// Control, ADC pin and sample signals of the LTC2308 reader.
interface adc_ltc2308_reader_if;
  import adc_pkg::*;

  logic                en;
  logic [2:0]          channel;
  logic                adc_sdo;
  logic                adc_convst;
  logic                adc_sck;
  logic                adc_sdi;
  logic [ADC_BITS-1:0] voltage;
  logic                valid;
  logic                busy;

  modport master (
    input  en, channel, adc_sdo,
    output adc_convst, adc_sck, adc_sdi, voltage, valid, busy
  );

  modport slave (
    output en, channel, adc_sdo,
    input  adc_convst, adc_sck, adc_sdi, voltage, valid, busy
  );

endinterface

// File: rtl/adc_sck_gen.sv
// SCK generator: CLK_DIV cycles low then CLK_DIV cycles high per bit, with
// single-cycle flags on the cycles whose ending edge raises or drops SCK.
module adc_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic sck_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);
  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;
  logic             phase_end;

  always_comb begin
    phase_end = en_i && (cnt_q == DIV_LAST);
    cnt_d     = '0;
    sck_d     = 1'b0;
    if (en_i) begin
      cnt_d = phase_end ? '0 : cnt_q + 1'b1;
      sck_d = phase_end ? ~sck_q : sck_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o       = sck_q;
  assign rise_tick_o = phase_end & ~sck_q;
  assign fall_tick_o = phase_end &  sck_q;

endmodule

// File: rtl/adc_ltc2308_reader.sv
// LTC2308 reader: drives CONVST/SCK/SDI, shifts in SDO and presents each
// completed 12-bit sample on voltage with a one-cycle valid strobe.
module adc_ltc2308_reader
  import adc_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 80,
  parameter int CONVST_HIGH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adc_ltc2308_reader_if.master bus
);
  localparam int               CNT_MAX   = (CONV_CYCLES > CONVST_HIGH) ? CONV_CYCLES : CONVST_HIGH;
  localparam int               CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(CONVST_HIGH - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(CONV_CYCLES - 1);
  localparam logic [3:0]       MSB_IDX   = 4'(ADC_BITS - 1);
  localparam logic [3:0]       CFG_LO    = 4'(ADC_BITS - CFG_BITS);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          bit_q, bit_d, bit_next;
  logic [2:0]          ch_q, ch_d;
  logic [CFG_BITS-1:0] cfg;
  logic                sdi_q, sdi_d;
  logic [ADC_BITS-1:0] shift_q, shift_d;
  logic [ADC_BITS-1:0] voltage_q, voltage_d;
  logic                valid_q, valid_d;
  logic                first_q, first_d;
  logic                sck, rise_tick, fall_tick;

  adc_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (state_q == SHIFT),
    .sck_o       (sck),
    .rise_tick_o (rise_tick),
    .fall_tick_o (fall_tick)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    ch_d      = ch_q;
    sdi_d     = sdi_q;
    shift_d   = shift_q;
    voltage_d = voltage_q;
    valid_d   = 1'b0;
    first_d   = first_q;
    cfg       = build_cfg(ch_q);
    bit_next  = bit_q - 4'd1;

    unique case (state_q)
      IDLE: if (bus.en) begin
        ch_d    = bus.channel;
        cnt_d   = '0;
        state_d = CONV;
      end
      CONV: if (cnt_q == HIGH_LAST) begin
        cnt_d   = '0;
        state_d = WAIT;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      WAIT: if (cnt_q == WAIT_LAST) begin
        cnt_d   = '0;
        bit_d   = MSB_IDX;
        sdi_d   = cfg[CFG_BITS-1];
        state_d = SHIFT;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      SHIFT: begin
        if (rise_tick) shift_d = {shift_q[ADC_BITS-2:0], bus.adc_sdo};
        if (fall_tick) begin
          if (bit_q == 4'd0) begin
            // Publish on entry to DONE so valid and the new voltage share that cycle.
            sdi_d     = 1'b0;
            voltage_d = shift_q;
            valid_d   = ~first_q;
            state_d   = DONE;
          end else begin
            bit_d = bit_next;
            sdi_d = (bit_next >= CFG_LO) ? cfg[3'(bit_next - CFG_LO)] : 1'b0;
          end
        end
      end
      DONE: begin
        first_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      ch_q      <= '0;
      sdi_q     <= 1'b0;
      shift_q   <= '0;
      voltage_q <= '0;
      valid_q   <= 1'b0;
      first_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking updates keep every register reading pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      ch_q      <= ch_d;
      sdi_q     <= sdi_d;
      shift_q   <= shift_d;
      voltage_q <= voltage_d;
      valid_q   <= valid_d;
      first_q   <= first_d;
    end
  end

  assign bus.adc_convst = (state_q == CONV);
  assign bus.adc_sck    = sck;
  assign bus.adc_sdi    = sdi_q;
  assign bus.voltage    = voltage_q;
  assign bus.valid      = valid_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: doc/adc_ltc2308_reader.md
Name: adc_ltc2308_reader

Overview:
- Serial ADC front end that drives the on-board LTC2308 and delivers 12-bit samples to the downstream amplitude/offset measurement stage.
- Generates CONVST/SCK/SDI, captures SDO, and presents each completed result on `voltage` with a one-cycle `valid` strobe.
- Runs free while `en` is high. Each frame programs the channel for the next conversion.

Parameters:
- CLK_DIV, 2, SCK half-period in clk cycles; SCK = clk/(2·CLK_DIV), 12.5 MHz at 50 MHz. Legal range ≥1.
- CONV_CYCLES, 80, clk cycles CONVST is held low before shifting; covers tCONV, 1.6 µs at 50 MHz. Legal range ≥1.
- CONVST_HIGH, 2, clk cycles CONVST pulse is high. Legal range ≥1.

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- en  input  1  level; start a new frame whenever idle and high
- channel  input  3  single-ended channel select, latched at frame start
- adc_sdo  input  1  ADC serial data out
- adc_convst  output  1  conversion start to ADC
- adc_sck  output  1  serial clock to ADC
- adc_sdi  output  1  config word to ADC
- voltage  output  12  last captured sample, unsigned straight binary
- valid  output  1  one-cycle pulse when `voltage` updates
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: adc_convst=0, adc_sck=0, adc_sdi=0, voltage=0, valid=0, busy=0.
  - Internal: state=IDLE, all counters=0, first_frame=1.
  - Reset mid-frame aborts immediately. No partial sample is ever output.
- IDLE:
  - If en=1: latch channel into ch_q, build cfg = {1'b1, ch_q[0], ch_q[2], ch_q[1], 1'b1, 1'b0}, i.e. S/D=single, O/S, S1, S0, UNI=unipolar, SLP=0.
  - Then go to CONV.
- CONV: adc_convst=1 for CONVST_HIGH cycles, then go to WAIT.
- WAIT: adc_convst=0 for CONV_CYCLES cycles, then go to SHIFT with bit index 11.
- SHIFT: 12 SCK periods, MSB first.
  - Each period is CLK_DIV cycles with sck=0, followed by CLK_DIV cycles with sck=1.
  - adc_sdi is updated on the first cycle of each low phase: cfg[5..0] for bits 0-5, 0 for bits 6-11.
  - adc_sdo is sampled into shift_reg on the clk edge that drives sck 0→1.
  - sck returns to 0 at the end of bit 11, then go to DONE.
- DONE (1 cycle):
  - voltage <= shift_reg.
  - valid=1 unless first_frame=1. The first frame after reset returns the stale pre-reset conversion, so it is suppressed.
  - first_frame <= 0, then go to IDLE.
- Latency:
  - A sample is output in the frame following its conversion, due to LTC2308 pipelining. The first valid appears at the end of the second frame.
  - Frame period with en held high = CONVST_HIGH + CONV_CYCLES + 24·CLK_DIV + 2 = 132 clk at defaults.
- Frame control:
  - en falling mid-frame: the current frame completes, including valid; the block then stays in IDLE.
  - channel changes mid-frame are ignored until the next IDLE latch.
- voltage holds its value between valid pulses.
- adc_sck idles low. adc_convst is never high outside CONV.

Decomposition:
- Package adc_pkg holds:
  - state encoding: IDLE, CONV, WAIT, SHIFT, DONE
  - ADC_BITS=12, CFG_BITS=6
  - config bit constants CFG_SD_SINGLE=1, CFG_UNIPOLAR=1, CFG_SLEEP=0
- Sub-module adc_sck_gen owns the CLK_DIV phase counter. It outputs the sck level plus single-cycle rise_tick/fall_tick flags, enabled only in SHIFT.
- The FSM and shift registers stay in the top module.

Test Plan:
- Reset then en=1, channel=3'd5, ADC model returns 12'hA5C each frame:
  - first DONE at cycle 131 has valid=0.
  - second DONE has valid=1, voltage=12'hA5C.
  - SDI bits captured by the model = 6'b1_1_1_0_1_0.
- en held high for 5 frames: valid pulses spaced exactly 132 clk apart; each is 1 cycle wide; CONVST high exactly 2 clk per frame.
- en dropped during SHIFT bit 4:
  - frame completes with valid=1 and the correct sample.
  - busy=0 afterwards; no further CONVST edges.
- rst_n asserted during SHIFT bit 7:
  - all outputs go to 0 the same instant, with no clk edge needed.
  - after release with en=1, the first frame's valid is suppressed again.
- channel changed 0→7 during WAIT: current frame's SDI carries the channel-0 config; the next frame carries 6'b1_1_1_1_1_0.
- CLK_DIV=1, CONV_CYCLES=1 build: sck toggles every clk and frame period = 29 clk. ADC model returns 12'hFFF, then 12'h000, then 12'h001, and each value is captured bit-exact.
